status_reg: RTL and testbench

- Processor status (P) register, directly downstream of the ALU.
- Captures the ALU's zero/negative/overflow/carry-out flags under per-flag write enables.
- Feeds carry (c_in) and decimal mode (bcd) back to the ALU, evaluates the eight branch conditions, and produces the P byte for PHP/BRK/interrupt pushes.
- Also synchronises IRQ and edge-detects NMI, so the control FSM sees one gated interrupt request.

---
 rtl/status_reg_pkg.sv | 54 +++++
 rtl/status_reg_if.sv | 37 +++
 rtl/status_reg_int_sync.sv | 30 +++
 rtl/status_reg.sv | 102 ++++++++++
 tb/tb_status_reg.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/status_reg_pkg.sv
// Shared CPU definitions: flag commands, branch conditions, P-bit positions
// and the branch evaluation helper used by the status register.
package cpu_pkg;

  typedef enum logic [2:0] {
    FC_NONE = 3'd0,
    FC_CLC  = 3'd1,
    FC_SEC  = 3'd2,
    FC_CLI  = 3'd3,
    FC_SEI  = 3'd4,
    FC_CLD  = 3'd5,
    FC_SED  = 3'd6,
    FC_CLV  = 3'd7
  } flag_cmd_t;

  typedef enum logic [2:0] {
    BR_BPL = 3'd0,
    BR_BMI = 3'd1,
    BR_BVC = 3'd2,
    BR_BVS = 3'd3,
    BR_BCC = 3'd4,
    BR_BCS = 3'd5,
    BR_BNE = 3'd6,
    BR_BEQ = 3'd7
  } br_cond_t;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  function automatic logic branch_eval(input br_cond_t cond, input logic n,
                                       input logic v, input logic z, input logic c);
    logic taken;
    taken = 1'b0;
    case (cond)
      BR_BPL: taken = ~n;
      BR_BMI: taken = n;
      BR_BVC: taken = ~v;
      BR_BVS: taken = v;
      BR_BCC: taken = ~c;
      BR_BCS: taken = c;
      BR_BNE: taken = ~z;
      BR_BEQ: taken = z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/status_reg_if.sv
// Control/ALU-side bundle of the processor status register.
interface status_reg_if;
  import cpu_pkg::*;

  logic       alu_zero;
  logic       alu_negative;
  logic       alu_overflow;
  logic       alu_c_out;
  logic [3:0] flag_we;
  flag_cmd_t  flag_cmd;
  logic       p_load;
  logic [7:0] p_in;
  logic       int_entry;
  logic       push_brk;
  br_cond_t   br_cond;
  logic       irq_n;
  logic       nmi_n;
  logic       nmi_ack;
  logic       carry;
  logic       decimal;
  logic [7:0] p_out;
  logic       branch_taken;
  logic       int_req;
  logic       nmi_pending;

  modport master (
    output alu_zero, alu_negative, alu_overflow, alu_c_out, flag_we, flag_cmd,
           p_load, p_in, int_entry, push_brk, br_cond, irq_n, nmi_n, nmi_ack,
    input  carry, decimal, p_out, branch_taken, int_req, nmi_pending
  );

  modport slave (
    input  alu_zero, alu_negative, alu_overflow, alu_c_out, flag_we, flag_cmd,
           p_load, p_in, int_entry, push_brk, br_cond, irq_n, nmi_n, nmi_ack,
    output carry, decimal, p_out, branch_taken, int_req, nmi_pending
  );
endinterface

// File: rtl/status_reg_int_sync.sv
// Multi-stage synchroniser for an active-low async input, with a registered
// history flop for synchronised falling-edge detection.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic async_n_i,
  output logic level_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Flops reset to the inactive (high) level so reset never fakes an edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_n_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = ~sync_q[STAGES-1];
  assign fall_o  = hist_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/status_reg.sv
// Processor status (P) register: ALU flag capture, flag commands, branch
// evaluation, push byte and IRQ/NMI request generation.
module status_reg
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_P     = 8'h24,
  parameter int         SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         resetb,
  status_reg_if.slave bus
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic nmi_pending_q;
  logic irq_sync, nmi_fall, irq_edge_unused;
  logic [1:0] p_in_unused;

  // Bits 5/4 of the pulled byte have no storage behind them.
  assign p_in_unused = bus.p_in[P_U:P_B];

  // Per-bit priority: p_load > int_entry (I only) > flag_cmd > flag_we > hold.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (bus.p_load) begin
      n_d = bus.p_in[P_N];
      v_d = bus.p_in[P_V];
      d_d = bus.p_in[P_D];
      i_d = bus.p_in[P_I];
      z_d = bus.p_in[P_Z];
      c_d = bus.p_in[P_C];
    end else begin
      if (bus.flag_we[3]) n_d = bus.alu_negative;
      if (bus.flag_cmd == FC_CLV)      v_d = 1'b0;
      else if (bus.flag_we[2])         v_d = bus.alu_overflow;
      if (bus.flag_we[1]) z_d = bus.alu_zero;
      if (bus.flag_cmd == FC_CLC)      c_d = 1'b0;
      else if (bus.flag_cmd == FC_SEC) c_d = 1'b1;
      else if (bus.flag_we[0])         c_d = bus.alu_c_out;
      if (bus.flag_cmd == FC_CLD)      d_d = 1'b0;
      else if (bus.flag_cmd == FC_SED) d_d = 1'b1;
      if (bus.int_entry)               i_d = 1'b1;
      else if (bus.flag_cmd == FC_CLI) i_d = 1'b0;
      else if (bus.flag_cmd == FC_SEI) i_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      n_q <= RESET_P[P_N];
      v_q <= RESET_P[P_V];
      d_q <= RESET_P[P_D];
      i_q <= RESET_P[P_I];
      z_q <= RESET_P[P_Z];
      c_q <= RESET_P[P_C];
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  int_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk       (clk),
    .resetb    (resetb),
    .async_n_i (bus.irq_n),
    .level_o   (irq_sync),
    .fall_o    (irq_edge_unused)
  );

  int_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk       (clk),
    .resetb    (resetb),
    .async_n_i (bus.nmi_n),
    .level_o   (),
    .fall_o    (nmi_fall)
  );

  // A fresh edge outranks an acknowledge arriving in the same cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)             nmi_pending_q <= 1'b0;
    else if (nmi_fall)       nmi_pending_q <= 1'b1;
    else if (bus.nmi_ack)    nmi_pending_q <= 1'b0;
  end

  assign bus.carry        = c_q;
  assign bus.decimal      = d_q;
  assign bus.p_out        = {n_q, v_q, 1'b1, bus.push_brk, d_q, i_q, z_q, c_q};
  assign bus.branch_taken = branch_eval(bus.br_cond, n_q, v_q, z_q, c_q);
  assign bus.nmi_pending  = nmi_pending_q;
  assign bus.int_req      = nmi_pending_q | (irq_sync & ~i_q);

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: vector table for flag updates, plus
// hand sequences for branches, IRQ masking, NMI edges and async reset.
module tb_status_reg;
  import cpu_pkg::*;

  typedef struct {
    logic [3:0] we;
    logic [2:0] cmd;
    logic       ld;
    logic [7:0] pin;
    logic       ie;
    logic       an, av, az, ac;
    logic       pb;
    logic [7:0] exp_p;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic resetb;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[15];
  exp_t sb[$];

  always #5 clk = ~clk;

  status_reg_if bus();

  status_reg #(.RESET_P(8'h24), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  function automatic vec_t mk(input logic [3:0] we, input logic [2:0] cmd,
                              input logic ld, input logic [7:0] pin, input logic ie,
                              input logic [3:0] nvzc, input logic pb, input logic [7:0] p);
    vec_t v;
    v.we = we; v.cmd = cmd; v.ld = ld; v.pin = pin; v.ie = ie;
    v.an = nvzc[3]; v.av = nvzc[2]; v.az = nvzc[1]; v.ac = nvzc[0];
    v.pb = pb; v.exp_p = p;
    return v;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic idle();
    bus.alu_zero = 0; bus.alu_negative = 0; bus.alu_overflow = 0; bus.alu_c_out = 0;
    bus.flag_we = 4'b0000; bus.flag_cmd = FC_NONE; bus.p_load = 0; bus.p_in = 8'h00;
    bus.int_entry = 0; bus.push_brk = 0; bus.br_cond = BR_BPL; bus.nmi_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_p(input logic [7:0] v);
    bus.p_load = 1'b1; bus.p_in = v;
    step();
    bus.p_load = 1'b0;
  endtask

  task automatic do_cmd(input flag_cmd_t c);
    bus.flag_cmd = c;
    step();
    bus.flag_cmd = FC_NONE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic [7:0] mask;

    //            we       cmd  ld  pin   ie  nvzc     pb  p_out
    vecs[0]  = mk(4'b0000, 3'd0, 0, 8'h00, 0, 4'b0000, 1, 8'h34);
    vecs[1]  = mk(4'b1111, 3'd0, 0, 8'h00, 0, 4'b1101, 0, 8'hE5);
    vecs[2]  = mk(4'b0010, 3'd1, 0, 8'h00, 0, 4'b0010, 0, 8'hE6);
    vecs[3]  = mk(4'b0000, 3'd5, 1, 8'hFF, 1, 4'b0000, 0, 8'hEF);
    vecs[4]  = mk(4'b0000, 3'd7, 0, 8'h00, 0, 4'b0000, 0, 8'hAF);
    vecs[5]  = mk(4'b0000, 3'd3, 0, 8'h00, 0, 4'b0000, 0, 8'hAB);
    vecs[6]  = mk(4'b1111, 3'd6, 0, 8'h00, 0, 4'b0000, 0, 8'h28);
    vecs[7]  = mk(4'b0000, 3'd5, 0, 8'h00, 1, 4'b0000, 0, 8'h24);
    vecs[8]  = mk(4'b0000, 3'd2, 0, 8'h00, 0, 4'b0000, 0, 8'h25);
    vecs[9]  = mk(4'b0000, 3'd2, 1, 8'h00, 0, 4'b0000, 0, 8'h20);
    vecs[10] = mk(4'b0001, 3'd4, 0, 8'h00, 0, 4'b0001, 0, 8'h25);
    vecs[11] = mk(4'b0000, 3'd3, 0, 8'h00, 1, 4'b0000, 0, 8'h25);
    vecs[12] = mk(4'b0000, 3'd0, 1, 8'h30, 0, 4'b0000, 0, 8'h20);
    vecs[13] = mk(4'b1100, 3'd7, 0, 8'h00, 0, 4'b1100, 0, 8'hA0);
    vecs[14] = mk(4'b0001, 3'd0, 0, 8'h00, 0, 4'b0001, 1, 8'hB1);

    idle();
    bus.irq_n = 1'b1;
    bus.nmi_n = 1'b1;
    resetb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk8("reset_p_out", bus.p_out, 8'h24);
    chk1("reset_carry", bus.carry, 1'b0);
    chk1("reset_decimal", bus.decimal, 1'b0);
    chk1("reset_int_req", bus.int_req, 1'b0);
    chk1("reset_nmi_pending", bus.nmi_pending, 1'b0);
    resetb = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      bus.flag_we = vecs[i].we;
      bus.flag_cmd = flag_cmd_t'(vecs[i].cmd);
      bus.p_load = vecs[i].ld;
      bus.p_in = vecs[i].pin;
      bus.int_entry = vecs[i].ie;
      bus.alu_negative = vecs[i].an;
      bus.alu_overflow = vecs[i].av;
      bus.alu_zero = vecs[i].az;
      bus.alu_c_out = vecs[i].ac;
      bus.push_brk = vecs[i].pb;
      sb.push_back('{$sformatf("vec%0d_p_out", i), vecs[i].exp_p});
      step();
      e = sb.pop_front();
      chk8(e.name, bus.p_out, e.val);
      chk1($sformatf("vec%0d_carry", i), bus.carry, e.val[P_C]);
      chk1($sformatf("vec%0d_decimal", i), bus.decimal, e.val[P_D]);
    end
    idle();

    // Branch conditions: expected taken mask indexed by br_cond.
    for (int k = 0; k < 3; k++) begin
      logic [7:0] pv;
      pv   = (k == 0) ? 8'h03 : (k == 1) ? 8'hC0 : 8'h00;
      mask = (k == 0) ? 8'hA5 : (k == 1) ? 8'h5A : 8'h55;
      load_p(pv);
      for (int c = 0; c < 8; c++) begin
        bus.br_cond = br_cond_t'(c[2:0]);
        sb.push_back('{$sformatf("branch_p%h_c%0d", pv, c), {7'd0, mask[c]}});
        #1;
        e = sb.pop_front();
        chk1(e.name, bus.branch_taken, e.val[0]);
      end
    end
    bus.br_cond = BR_BPL;

    // IRQ: sync latency with I=0, then masking by I.
    bus.irq_n = 1'b0;
    step();
    chk1("irq_sync_early", bus.int_req, 1'b0);
    step();
    chk1("irq_sync_latency", bus.int_req, 1'b1);
    bus.irq_n = 1'b1;
    step();
    step();
    chk1("irq_release", bus.int_req, 1'b0);
    do_cmd(FC_SEI);
    bus.irq_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1($sformatf("irq_masked_%0d", i), bus.int_req, 1'b0);
    end
    do_cmd(FC_CLI);
    n = 0;
    while (!bus.int_req && n < 3) begin
      step();
      n++;
    end
    chk1("irq_unmasked", bus.int_req, 1'b1);
    do_cmd(FC_SEI);
    chk1("irq_remasked", bus.int_req, 1'b0);
    bus.irq_n = 1'b1;
    repeat (3) step();

    // NMI: edge with I=1, ack, held low, edge coincident with ack.
    bus.nmi_n = 1'b0;
    step();
    step();
    chk1("nmi_not_yet", bus.nmi_pending, 1'b0);
    step();
    chk1("nmi_pending", bus.nmi_pending, 1'b1);
    chk1("nmi_int_req_unmasked", bus.int_req, 1'b1);
    bus.nmi_ack = 1'b1;
    step();
    bus.nmi_ack = 1'b0;
    chk1("nmi_acked", bus.nmi_pending, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("nmi_held_low_%0d", i), bus.nmi_pending, 1'b0);
    end
    bus.nmi_n = 1'b1;
    repeat (4) step();
    bus.nmi_n = 1'b0;
    step();
    step();
    bus.nmi_ack = 1'b1;
    step();
    bus.nmi_ack = 1'b0;
    chk1("nmi_edge_beats_ack", bus.nmi_pending, 1'b1);
    bus.nmi_ack = 1'b1;
    step();
    bus.nmi_ack = 1'b0;
    chk1("nmi_ack_again", bus.nmi_pending, 1'b0);

    // Mid-operation async reset discards a pending NMI and restores P.
    bus.nmi_n = 1'b1;
    repeat (4) step();
    bus.nmi_n = 1'b0;
    repeat (3) step();
    load_p(8'hC3);
    chk1("pre_reset_pending", bus.nmi_pending, 1'b1);
    chk8("pre_reset_p_out", bus.p_out, 8'hE3);
    #2 resetb = 1'b0;
    #1;
    chk8("async_reset_p_out", bus.p_out, 8'h24);
    chk1("async_reset_pending", bus.nmi_pending, 1'b0);
    chk1("async_reset_carry", bus.carry, 1'b0);
    bus.nmi_n = 1'b1;
    @(negedge clk);
    resetb = 1'b1;
    repeat (4) step();
    chk1("post_reset_pending", bus.nmi_pending, 1'b0);
    chk1("post_reset_int_req", bus.int_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
